// File: rtl/washer_fsm_pkg.sv
// washer_fsm_pkg
// Shared definitions for the washing-machine cycle controller.
//   state_e    : 3-bit state encoding, IDLE=0 then FILL1..SPIN in sequence order
//   SPEED_LOW  : motor speed select for wash/rinse agitation
//   SPEED_HIGH : motor speed select for spin
package washer_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL1  = 3'd1,
    WASH   = 3'd2,
    DRAIN1 = 3'd3,
    FILL2  = 3'd4,
    RINSE  = 3'd5,
    DRAIN2 = 3'd6,
    SPIN   = 3'd7
  } state_e;

  localparam logic SPEED_LOW  = 1'b0;
  localparam logic SPEED_HIGH = 1'b1;

endpackage

// File: rtl/washer_fsm_if.sv
// washer_fsm_if
// Bundle of front-panel/timer inputs and actuator outputs of the washer
// controller.
//   master : the panel/timer side; drives Door, Start, Tf, Tw, Td, Tr, Ts
//            and observes the actuator outputs.
//   slave  : the controller; consumes the inputs and drives Water,
//            Agitator, Motor, Speed, Pump and the timer restart R.
interface washer_fsm_if;
  logic Door;
  logic Start;
  logic Tf;
  logic Tw;
  logic Td;
  logic Tr;
  logic Ts;
  logic Water;
  logic Agitator;
  logic Motor;
  logic Speed;
  logic Pump;
  logic R;

  modport master (
    output Door, Start, Tf, Tw, Td, Tr, Ts,
    input  Water, Agitator, Motor, Speed, Pump, R
  );

  modport slave (
    input  Door, Start, Tf, Tw, Td, Tr, Ts,
    output Water, Agitator, Motor, Speed, Pump, R
  );
endinterface

// File: rtl/washer_fsm.sv
// washer_fsm
// Moore state machine sequencing a wash cycle:
//   IDLE -> FILL1 -> WASH -> DRAIN1 -> FILL2 -> RINSE -> DRAIN2 -> SPIN -> IDLE
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-low; forces IDLE and clears R
//   bus   : washer_fsm_if.slave; phase-done inputs, door/start and the
//           actuator outputs plus the one-cycle phase-timer restart R
module washer_fsm
  import washer_fsm_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  washer_fsm_if.slave   bus
);

  localparam logic [2:0] S_IDLE   = 3'(IDLE);
  localparam logic [2:0] S_FILL1  = 3'(FILL1);
  localparam logic [2:0] S_WASH   = 3'(WASH);
  localparam logic [2:0] S_DRAIN1 = 3'(DRAIN1);
  localparam logic [2:0] S_FILL2  = 3'(FILL2);
  localparam logic [2:0] S_RINSE  = 3'(RINSE);
  localparam logic [2:0] S_DRAIN2 = 3'(DRAIN2);
  localparam logic [2:0] S_SPIN   = 3'(SPIN);

  logic [2:0] state_reg;
  logic [2:0] state_next;
  logic       r_reg;

  logic water;
  logic agitator;
  logic motor;
  logic speed;
  logic pump;

  // State register. R flags that the edge just taken changed the state;
  // the reset path clears it so reset itself never restarts the timer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      r_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      r_reg     <= (state_next != state_reg);
    end
  end

  // Next state: each state listens only to its own completion input.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (bus.Start && !bus.Door) state_next = S_FILL1;
      S_FILL1:  if (bus.Tf)                 state_next = S_WASH;
      S_WASH:   if (bus.Tw)                 state_next = S_DRAIN1;
      S_DRAIN1: if (bus.Td)                 state_next = S_FILL2;
      S_FILL2:  if (bus.Tf)                 state_next = S_RINSE;
      S_RINSE:  if (bus.Tr)                 state_next = S_DRAIN2;
      S_DRAIN2: if (bus.Td)                 state_next = S_SPIN;
      S_SPIN:   if (bus.Ts && !bus.Door)    state_next = S_IDLE;
      default:                              state_next = S_IDLE;
    endcase
  end

  // Output decode. In SPIN the drum stops combinationally with an open
  // door so it halts in the same cycle; the pump keeps draining.
  always_comb begin
    water    = 1'b0;
    agitator = 1'b0;
    motor    = 1'b0;
    speed    = SPEED_LOW;
    pump     = 1'b0;
    case (state_reg)
      S_FILL1, S_FILL2: water = 1'b1;
      S_WASH, S_RINSE: begin
        agitator = 1'b1;
        motor    = 1'b1;
        speed    = SPEED_LOW;
      end
      S_DRAIN1, S_DRAIN2: pump = 1'b1;
      S_SPIN: begin
        pump  = 1'b1;
        motor = !bus.Door;
        speed = bus.Door ? SPEED_LOW : SPEED_HIGH;
      end
      default: ;
    endcase
  end

  assign bus.Water    = water;
  assign bus.Agitator = agitator;
  assign bus.Motor    = motor;
  assign bus.Speed    = speed;
  assign bus.Pump     = pump;
  assign bus.R        = r_reg;

endmodule

// File: tb/tb_washer_fsm.sv
// tb_washer_fsm
// Self-checking bench for washer_fsm. Each step drives inputs on the falling
// edge; a behavioural model pushes the expected outputs into a scoreboard
// queue, and they are popped and compared just after the drive (to catch
// the combinational door term) and just after the following rising edge.
module tb_washer_fsm;

  logic clk;
  logic reset;

  washer_fsm_if bus();

  washer_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;
  int r_count;

  // Model state: 0=IDLE,1=FILL1,2=WASH,3=DRAIN1,4=FILL2,5=RINSE,6=DRAIN2,7=SPIN
  int   m_state;
  logic m_r;

  logic [5:0] sb[$];

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  // {Water, Agitator, Motor, Speed, Pump}
  function automatic logic [4:0] model_outs(input int st, input logic door);
    logic [4:0] o;
    if (st == 1 || st == 4)      o = 5'b10000;
    else if (st == 2 || st == 5) o = 5'b01100;
    else if (st == 3 || st == 6) o = 5'b00001;
    else if (st == 7)            o = door ? 5'b00001 : 5'b00111;
    else                         o = 5'b00000;
    return o;
  endfunction

  function automatic logic [5:0] observe();
    return {bus.Water, bus.Agitator, bus.Motor, bus.Speed, bus.Pump, bus.R};
  endfunction

  task automatic step(input string tag, input logic rst_n, input logic door,
                      input logic start, input logic tf, input logic tw,
                      input logic td, input logic tr, input logic ts);
    int ns;
    logic [5:0] got;
    @(negedge clk);
    reset     = rst_n;
    bus.Door  = door;
    bus.Start = start;
    bus.Tf    = tf;
    bus.Tw    = tw;
    bus.Td    = td;
    bus.Tr    = tr;
    bus.Ts    = ts;
    sb.push_back({model_outs(m_state, door), m_r});
    #1;
    got = observe();
    check({tag, "/pre"}, got, sb.pop_front());

    ns = m_state;
    unique case (m_state)
      0: if (start && !door) ns = 1;
      1: if (tf) ns = 2;
      2: if (tw) ns = 3;
      3: if (td) ns = 4;
      4: if (tf) ns = 5;
      5: if (tr) ns = 6;
      6: if (td) ns = 7;
      7: if (ts && !door) ns = 0;
      default: ns = 0;
    endcase
    if (!rst_n) begin
      ns  = 0;
      m_r = 1'b0;
    end else begin
      m_r = (ns != m_state);
    end
    m_state = ns;
    sb.push_back({model_outs(m_state, door), m_r});

    @(posedge clk);
    #1;
    got = observe();
    check(tag, got, sb.pop_front());
    if (got[0] === 1'b1) r_count++;
    $display("step %-12s state=%0d outs=%b", tag, m_state, got);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    r_count = 0;
    m_state = 0;
    m_r     = 1'b0;
    reset     = 1'b0;
    bus.Door  = 1'b0;
    bus.Start = 1'b1;
    bus.Tf    = 1'b0;
    bus.Tw    = 1'b0;
    bus.Td    = 1'b0;
    bus.Tr    = 1'b0;
    bus.Ts    = 1'b0;
    repeat (2) @(posedge clk);

    //                 tag          rst door st tf tw td tr ts
    step("reset0",     0, 0, 1, 0, 0, 0, 0, 0);
    step("reset1",     0, 0, 1, 0, 0, 0, 0, 0);
    step("reset2",     0, 0, 1, 0, 0, 0, 0, 0);
    r_count = 0;
    step("release",    1, 0, 1, 0, 0, 0, 0, 0);
    step("fill1_tw",   1, 0, 0, 0, 1, 0, 0, 0);
    step("fill1_tf",   1, 0, 0, 1, 0, 0, 0, 0);
    step("wash_tfhold",1, 0, 0, 1, 0, 0, 0, 0);
    step("wash_td",    1, 0, 0, 0, 0, 1, 0, 0);
    step("wash_tw",    1, 0, 0, 0, 1, 0, 0, 0);
    step("drain1_tw",  1, 0, 0, 0, 1, 0, 0, 0);
    step("drain1_td",  1, 0, 0, 0, 0, 1, 0, 0);
    step("fill2_td",   1, 0, 0, 0, 0, 1, 0, 0);
    step("fill2_tf",   1, 0, 0, 1, 0, 0, 0, 0);
    step("rinse_tf",   1, 0, 0, 1, 0, 0, 0, 0);
    step("rinse_tr",   1, 0, 0, 0, 0, 0, 1, 0);
    step("drain2_tr",  1, 0, 0, 0, 0, 0, 1, 0);
    step("drain2_td",  1, 0, 0, 0, 0, 1, 0, 0);
    step("spin_td",    1, 0, 0, 0, 0, 1, 0, 0);
    step("spin_door0", 1, 1, 0, 0, 0, 0, 0, 1);
    step("spin_door1", 1, 1, 0, 0, 0, 0, 0, 1);
    step("spin_ts",    1, 0, 0, 0, 0, 0, 0, 1);
    check("r_pulses", 6'(r_count), 6'd8);

    step("idle_door0", 1, 1, 1, 0, 0, 0, 0, 0);
    step("idle_door1", 1, 1, 1, 0, 0, 0, 0, 0);
    step("idle_start", 1, 0, 1, 0, 0, 0, 0, 0);
    step("b_fill1",    1, 0, 0, 1, 0, 0, 0, 0);
    step("b_wash",     1, 0, 0, 0, 1, 0, 0, 0);
    step("b_drain1",   1, 0, 0, 0, 0, 1, 0, 0);
    step("b_fill2",    1, 0, 0, 1, 0, 0, 0, 0);
    step("rinse_rst",  0, 0, 0, 0, 0, 0, 1, 0);
    step("post_rst",   1, 0, 0, 0, 0, 0, 0, 0);

    check("sb_empty", 6'(sb.size()), 6'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/washer_fsm.md
# washer_fsm

Washing-machine cycle controller: a single Moore state machine that sequences fill, wash, drain, fill, rinse, drain and spin from external phase-done inputs. It sits between the front-panel and timer logic and the machine's actuators (water valve, agitator, drum motor, drain pump). It also issues a one-cycle restart pulse to the external phase timer on every state change.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; reset=0 at a rising edge forces IDLE.
- Door  in  1  1 = lid open; 0 = lid closed.
- Start  in  1  level request to begin a cycle.
- Tf  in  1  fill complete (tub full).
- Tw  in  1  wash period elapsed.
- Td  in  1  drain complete.
- Tr  in  1  rinse period elapsed.
- Ts  in  1  spin period elapsed.
- Water  out  1  inlet water valve open.
- Agitator  out  1  agitator engaged.
- Motor  out  1  drum motor running.
- Speed  out  1  motor speed select: 1 = high (spin), 0 = low.
- Pump  out  1  drain pump on.
- R  out  1  phase-timer restart; one-cycle pulse after every state change.

## Operation
- States: IDLE, FILL1, WASH, DRAIN1, FILL2, RINSE, DRAIN2, SPIN.
- Transitions are evaluated at each rising edge with reset=1. Only the listed input matters in each state; all other inputs are ignored.
  - IDLE -> FILL1 on Start=1 and Door=0.
  - FILL1 -> WASH on Tf.
  - WASH -> DRAIN1 on Tw.
  - DRAIN1 -> FILL2 on Td.
  - FILL2 -> RINSE on Tf.
  - RINSE -> DRAIN2 on Tr.
  - DRAIN2 -> SPIN on Td.
  - SPIN -> IDLE on Ts=1 and Door=0.
  - Otherwise the FSM holds its state.
- Inputs are level-sensitive. A signal held high across a transition is honored by the next state only if that state uses it. Example: Tf still high on entry to WASH has no effect.
- Outputs are decoded from the state register (Moore); any output not listed for a state is 0.
  - IDLE: all outputs 0.
  - FILL1, FILL2: Water=1.
  - WASH, RINSE: Agitator=1, Motor=1, Speed=0.
  - DRAIN1, DRAIN2: Pump=1.
  - SPIN with Door=0: Motor=1, Speed=1, Pump=1.
  - SPIN with Door=1: Motor=0, Speed=0, Pump=1. The state is held and Ts is ignored until the door closes.
- Door interlock:
  - An open door in IDLE blocks Start.
  - An open door in SPIN stops the drum and freezes the state.
  - Door is ignored in all other states.
- R: registered flag, set to 1 for exactly one cycle following any edge where the state changed, including SPIN->IDLE. Otherwise R=0.
- Reset mid-cycle returns to IDLE immediately. R is not pulsed by reset.

## Timing
- Reset values: state=IDLE; Water=Agitator=Motor=Speed=Pump=R=0.
- Latency is one clock. A qualifying input present at edge N changes the state at edge N, so the new outputs are visible after edge N.
- R is high during the cycle between edge N and edge N+1.
- Consecutive transitions on consecutive edges are legal. R then stays high for each of those cycles.
- The Door term in SPIN outputs is combinational from Door, so the motor drops in the same cycle the door opens.
- Start held high at the end of SPIN->IDLE restarts the cycle on the next edge. This auto-restart is intended.

## Structure
- The shared package holds the state enum (3-bit encoding; IDLE=0, then FILL1..SPIN = 1..7 in sequence order) and named constants for Speed (SPEED_LOW=0, SPEED_HIGH=1).
- Single module, no sub-modules, with three parts:
  - state register;
  - next-state combinational block;
  - output decode plus the R flag register.

## Test plan
- Reset: hold reset=0 for 3 edges with Start=1 -> state IDLE, all outputs 0, R=0. Release reset -> FILL1 on the next edge, Water=1, R=1 for one cycle.
- Full cycle: assert Start, Tf, Tw, Td, Tf, Tr, Td, Ts in turn, each held 2 cycles. The required state order is:
  - FILL1: Water.
  - WASH: Agitator, Motor.
  - DRAIN1: Pump.
  - FILL2: Water.
  - RINSE: Agitator, Motor.
  - DRAIN2: Pump.
  - SPIN: Motor, Speed=1, Pump.
  - IDLE.
  - R pulses exactly 8 times.
- Ignored inputs: Tw=1 in FILL1, or Tf held high on entry to WASH -> no state change. Td=1 in WASH -> stays in WASH.
- Door in SPIN: Door=1 for 2 cycles with Ts=1 -> Motor=0, Speed=0, Pump=1, stays in SPIN. Door=0 -> Motor=1, Speed=1 that cycle, IDLE on the next edge.
- Door in IDLE: Door=1 with Start=1 -> remains IDLE. Door=0 -> FILL1.
- Mid-cycle reset: reset=0 in RINSE -> IDLE on that edge, outputs all 0, R=0.
